// File: rtl/uart_frame_defs_pkg.sv
// Shared definitions for the UART frame scheduler: FSM encoding, frame layout
// constants and the byte-mapping helper used when sequencing a frame.
package uart_frame_defs;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SEND  = 3'd2,
      ST_GUARD = 3'd3,
      ST_WAIT  = 3'd4
   } state_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
   localparam int         FRAME_LEN         = 5;

   localparam logic [2:0] IDX_SYNC = 3'd0;
   localparam logic [2:0] IDX_ID   = 3'd1;
   localparam logic [2:0] IDX_HI   = 3'd2;
   localparam logic [2:0] IDX_LO   = 3'd3;
   localparam logic [2:0] IDX_CSUM = 3'(FRAME_LEN - 1);

   // Checksum is a truncating 8-bit sum of id, high and low bytes; sync is excluded.
   function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                             input logic [7:0]  sync_byte,
                                             input logic [7:0]  chan_id,
                                             input logic [15:0] data);
      logic [7:0] b;
      case (idx)
         IDX_SYNC: b = sync_byte;
         IDX_ID:   b = chan_id;
         IDX_HI:   b = data[15:8];
         IDX_LO:   b = data[7:0];
         default:  b = chan_id + data[15:8] + data[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/uart_frame_scheduler_rr_pick.sv
// Combinational round-robin selector: the lowest requesting index at or after
// the pointer, wrapping around, wins.
module rr_pick #(
   parameter  int N_REQ = 4,
   localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic             grant_valid,
   output logic [IW-1:0]    grant_idx
);

   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a,
                                              input logic [IW-1:0] b);
      logic [IW:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= (IW+1)'(N_REQ))
         s = s - (IW+1)'(N_REQ);
      return s[IW-1:0];
   endfunction

   // Requests rotated so that position 0 corresponds to the pointer.
   logic [N_REQ-1:0] rot;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_rot
         assign rot[gi] = req[wrap_add(ptr, IW'(gi))];
      end
   endgenerate

   logic [IW-1:0] offset;

   always_comb begin
      grant_valid = 1'b0;
      offset      = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            grant_valid = 1'b1;
            offset      = IW'(k);
         end
      end
      grant_idx = wrap_add(ptr, offset);
   end

endmodule

// File: rtl/uart_frame_scheduler.sv
// Shares one UART byte transmitter among N_REQ sensor requesters: round-robin
// grant, payload latch, and a 5-byte frame (sync, id, hi, lo, checksum).
module uart_frame_scheduler
   import uart_frame_defs::*;
#(
   parameter  int         N_REQ        = 4,
   parameter  int         GUARD_CYCLES = 4,
   parameter  logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
   localparam int         IW           = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*16-1:0] payload,
   output logic [N_REQ-1:0]    ack,
   output logic                tx_start,
   output logic [7:0]          tx_data,
   input  logic                tx_busy,
   output logic                frame_done,
   output logic                busy
);

   localparam int GW = $clog2(GUARD_CYCLES + 1);

   state_t        state_reg,    state_next;
   logic [IW-1:0] ptr_reg,      ptr_next;
   logic [IW-1:0] winner_reg,   winner_next;
   logic [15:0]   payload_reg,  payload_next;
   logic [2:0]    byte_idx_reg, byte_idx_next;
   logic [GW-1:0] guard_reg,    guard_next;
   logic [7:0]    tx_data_reg,  tx_data_next;

   logic          grant_valid;
   logic [IW-1:0] grant_idx;
   logic [7:0]    chan_id;
   logic [15:0]   payload_arr [N_REQ];

   rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
      .req         (req),
      .ptr         (ptr_reg),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_chan
         assign payload_arr[gi] = payload[16*gi +: 16];
         assign ack[gi]         = (state_reg == ST_LOAD) && (winner_reg == IW'(gi));
      end
   endgenerate

   assign chan_id = {{(8-IW){1'b0}}, winner_reg};
   assign tx_data = tx_data_reg;
   assign busy    = (state_reg != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         ptr_reg      <= '0;
         winner_reg   <= '0;
         payload_reg  <= '0;
         byte_idx_reg <= '0;
         guard_reg    <= '0;
         tx_data_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         ptr_reg      <= ptr_next;
         winner_reg   <= winner_next;
         payload_reg  <= payload_next;
         byte_idx_reg <= byte_idx_next;
         guard_reg    <= guard_next;
         tx_data_reg  <= tx_data_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      ptr_next      = ptr_reg;
      winner_next   = winner_reg;
      payload_next  = payload_reg;
      byte_idx_next = byte_idx_reg;
      guard_next    = guard_reg;
      tx_data_next  = tx_data_reg;
      tx_start      = 1'b0;
      frame_done    = 1'b0;

      case (state_reg)
         // A transmitter still busy from before a reset blocks new grants here.
         ST_IDLE: begin
            if (!tx_busy && grant_valid) begin
               winner_next = grant_idx;
               state_next  = ST_LOAD;
            end
         end
         ST_LOAD: begin
            payload_next  = payload_arr[winner_reg];
            byte_idx_next = IDX_SYNC;
            tx_data_next  = SYNC_BYTE;
            state_next    = ST_SEND;
         end
         ST_SEND: begin
            tx_start   = 1'b1;
            guard_next = GW'(GUARD_CYCLES - 1);
            state_next = ST_GUARD;
         end
         // tx_busy is not trusted until the transmitter has seen the start pulse.
         ST_GUARD: begin
            if (guard_reg == '0)
               state_next = ST_WAIT;
            else
               guard_next = guard_reg - GW'(1);
         end
         ST_WAIT: begin
            if (!tx_busy) begin
               if (byte_idx_reg == IDX_CSUM) begin
                  frame_done = 1'b1;
                  ptr_next   = (winner_reg == IW'(N_REQ - 1)) ? '0 : winner_reg + IW'(1);
                  state_next = ST_IDLE;
               end else begin
                  byte_idx_next = byte_idx_reg + 3'd1;
                  tx_data_next  = frame_byte(byte_idx_reg + 3'd1, SYNC_BYTE, chan_id, payload_reg);
                  state_next    = ST_SEND;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Directed bench for uart_frame_scheduler with a simple transmitter model
// whose busy delay and length are set per test.
module tb_uart_frame_scheduler;

   localparam int N_REQ = 4;
   localparam int GUARD = 4;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [N_REQ-1:0]    req;
   logic [N_REQ*16-1:0] payload;
   logic [N_REQ-1:0]    ack;
   logic                tx_start;
   logic [7:0]          tx_data;
   logic                tx_busy;
   logic                frame_done;
   logic                busy;

   always #10 clk = ~clk;

   uart_frame_scheduler #(
      .N_REQ        (N_REQ),
      .GUARD_CYCLES (GUARD),
      .SYNC_BYTE    (8'hA5)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .payload    (payload),
      .ack        (ack),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .tx_busy    (tx_busy),
      .frame_done (frame_done),
      .busy       (busy)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Transmitter model: busy from busy_delay cycles after start, for busy_len cycles.
   int busy_delay = 3;
   int busy_len   = 2;
   int tx_age     = -1;

   initial begin
      tx_busy = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (tx_start)
            tx_age = 0;
         else if (tx_age >= 0)
            tx_age++;
         if (tx_age >= busy_delay + busy_len)
            tx_age = -1;
         tx_busy = (tx_age >= busy_delay);
      end
   end

   // Monitor: logs starts, acks and frame_done, and checks start spacing.
   int         cyc        = 0;
   int         last_start = -1000;
   int         fd_count   = 0;
   logic [7:0] bytes [$];
   int         ack_ch [$];
   int         ack_cyc [$];
   int         fd_cyc [$];

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (tx_start) begin
            bytes.push_back(tx_data);
            check("start_gap", 32'((cyc - last_start) >= GUARD + 2), 32'd1);
            check("start_while_busy", 32'(tx_busy), 32'd0);
            last_start = cyc;
            $display("[%0d] tx_start byte=%02h", cyc, tx_data);
         end
         if (ack != '0) begin
            for (int i = 0; i < N_REQ; i++)
               if (ack[i]) ack_ch.push_back(i);
            ack_cyc.push_back(cyc);
            $display("[%0d] ack=%b", cyc, ack);
         end
         if (frame_done) begin
            fd_count++;
            fd_cyc.push_back(cyc);
            $display("[%0d] frame_done", cyc);
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic clear_logs();
      bytes.delete();
      ack_ch.delete();
      ack_cyc.delete();
      fd_cyc.delete();
   endtask

   task automatic wait_fd(input string tag, input int target, input int bound);
      int k = 0;
      while (fd_count < target && k < bound) begin
         tick();
         k++;
      end
      check(tag, 32'(fd_count), 32'(target));
   endtask

   task automatic wait_ack(input string tag, input int n, input int bound);
      int k = 0;
      while (ack_ch.size() < n && k < bound) begin
         tick();
         k++;
      end
      check(tag, 32'(ack_ch.size()), 32'(n));
   endtask

   task automatic check_frame(input string tag, input int base,
                              input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input logic [7:0] b4);
      logic [7:0] exp [5];
      exp = '{b0, b1, b2, b3, b4};
      check({tag, "_len"}, 32'(bytes.size() >= base + 5), 32'd1);
      if (bytes.size() >= base + 5)
         for (int i = 0; i < 5; i++)
            check($sformatf("%s_b%0d", tag, i), 32'(bytes[base+i]), 32'(exp[i]));
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int fd0;
      int a0;
      int blocked;
      int k;

      rst_n   = 1'b0;
      req     = '0;
      payload = '0;
      tick(3);
      check("rst_ack",        32'(ack),        32'd0);
      check("rst_tx_start",   32'(tx_start),   32'd0);
      check("rst_tx_data",    32'(tx_data),    32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_busy",       32'(busy),       32'd0);
      rst_n = 1'b1;
      tick(2);

      // Single requester: latency and frame contents.
      clear_logs();
      fd0 = fd_count;
      payload[15:0] = 16'h3A19;
      req = 4'b0001;
      tick();
      check("t1_ack_latency", 32'(ack), 32'b0001);
      check("t1_busy_load",   32'(busy), 32'd1);
      req = '0;
      tick();
      check("t1_start_latency", 32'(tx_start), 32'd1);
      check("t1_first_byte",    32'(tx_data),  32'hA5);
      wait_fd("t1_frame_done", fd0 + 1, 300);
      tick();
      check("t1_busy_after", 32'(busy), 32'd0);
      tick(10);
      check_frame("t1", 0, 8'hA5, 8'h00, 8'h3A, 8'h19, 8'h53);
      check("t1_nbytes", 32'(bytes.size()), 32'd5);
      check("t1_fd_count", 32'(fd_count), 32'(fd0 + 1));

      // Round-robin over 1011, four frames: 0, 1, 3, then wrap to 0.
      do_reset();
      clear_logs();
      fd0 = fd_count;
      payload = '0;
      payload[15:0]  = 16'h1111;
      payload[31:16] = 16'h2222;
      payload[63:48] = 16'h4444;
      req = 4'b1011;
      wait_ack("t2_acks", 4, 400);
      req = '0;
      wait_fd("t2_frame_done", fd0 + 4, 300);
      tick(10);
      if (ack_ch.size() >= 4) begin
         check("t2_order0", 32'(ack_ch[0]), 32'd0);
         check("t2_order1", 32'(ack_ch[1]), 32'd1);
         check("t2_order2", 32'(ack_ch[2]), 32'd3);
         check("t2_order3", 32'(ack_ch[3]), 32'd0);
      end
      if (ack_cyc.size() >= 2 && fd_cyc.size() >= 1)
         check("t2_b2b_gap", 32'(ack_cyc[1] - fd_cyc[0]), 32'd2);
      check("t2_nbytes", 32'(bytes.size()), 32'd20);
      check_frame("t2_f1", 5,  8'hA5, 8'h01, 8'h22, 8'h22, 8'h45);
      check_frame("t2_f2", 10, 8'hA5, 8'h03, 8'h44, 8'h44, 8'h8B);
      check_frame("t2_f3", 15, 8'hA5, 8'h00, 8'h11, 8'h11, 8'h22);

      // Checksum wrap, and a payload change after latch must not leak in.
      do_reset();
      clear_logs();
      fd0 = fd_count;
      payload = '0;
      payload[47:32] = 16'hFFFF;
      req = 4'b0100;
      wait_ack("t3_ack", 1, 20);
      req = '0;
      tick();
      payload[47:32] = 16'h1234;
      wait_fd("t3_frame_done", fd0 + 1, 300);
      tick(5);
      check_frame("t3", 0, 8'hA5, 8'h02, 8'hFF, 8'hFF, 8'h00);

      // Long busy handshake plus a one-cycle req[1] pulse while busy.
      do_reset();
      clear_logs();
      busy_len = 100;
      fd0 = fd_count;
      payload = '0;
      payload[15:0]  = 16'h0102;
      payload[31:16] = 16'h7777;
      req = 4'b0001;
      wait_ack("t4_ack", 1, 20);
      req = '0;
      tick(20);
      check("t4_busy_mid", 32'(busy), 32'd1);
      req[1] = 1'b1;
      tick();
      req[1] = 1'b0;
      wait_fd("t4_frame_done", fd0 + 1, 3000);
      tick(30);
      check("t4_nstarts", 32'(bytes.size()), 32'd5);
      check_frame("t4", 0, 8'hA5, 8'h00, 8'h01, 8'h02, 8'h03);
      check("t4_nacks", 32'(ack_ch.size()), 32'd1);
      check("t4_fd_count", 32'(fd_count), 32'(fd0 + 1));

      // Reset mid-frame after byte 2 while the transmitter is busy.
      busy_len = 30;
      do_reset();
      clear_logs();
      payload = '0;
      payload[63:48] = 16'h5566;
      req = 4'b1000;
      k = 0;
      while (bytes.size() < 3 && k < 200) begin
         tick();
         k++;
      end
      check("t5_reach_byte2", 32'(bytes.size()), 32'd3);
      k = 0;
      while (!tx_busy && k < 20) begin
         tick();
         k++;
      end
      check("t5_tx_busy", 32'(tx_busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t5_rst_ack",        32'(ack),        32'd0);
      check("t5_rst_tx_start",   32'(tx_start),   32'd0);
      check("t5_rst_tx_data",    32'(tx_data),    32'd0);
      check("t5_rst_frame_done", 32'(frame_done), 32'd0);
      check("t5_rst_busy",       32'(busy),       32'd0);
      tick(2);
      rst_n = 1'b1;
      clear_logs();
      fd0 = fd_count;
      blocked = 0;
      k = 0;
      while (tx_busy && k < 100) begin
         if (ack != '0 || busy) blocked = 1;
         tick();
         k++;
      end
      check("t5_no_grant_busy", 32'(blocked), 32'd0);
      wait_ack("t5_ack", 1, 20);
      req = '0;
      wait_fd("t5_frame_done", fd0 + 1, 1000);
      tick(5);
      check_frame("t5", 0, 8'hA5, 8'h03, 8'h55, 8'h66, 8'hBE);
      check("t5_fd_count", 32'(fd_count), 32'(fd0 + 1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
